// File: rtl/switch_debounce_pulse.sv
// ---------------------------------------------------------------------------
// switch_debounce_pulse
//
// Debounces a raw mechanical switch/button and reports the accepted level
// plus one-cycle press/release strobes.
//
// The raw input is brought into the clock domain by a 2-flop synchronizer.
// A four-state FSM then requires the synchronized level to stay stable for
// exactly par_T_debounce_val cycles before accepting a change.
//
// Parameters
//   par_T_debounce_bits : width of the debounce timer
//                         (2**bits must exceed par_T_debounce_val)
//   par_T_debounce_val  : stable cycles required to accept a change (>= 2)
//
// Ports
//   i_clk           : clock, rising edge
//   i_rstn          : synchronous active-low reset
//   i_sw            : raw asynchronous switch level
//   o_sw_level      : debounced switch level
//   o_press_pulse   : one-cycle strobe on an accepted 0->1 change
//   o_release_pulse : one-cycle strobe on an accepted 1->0 change
// ---------------------------------------------------------------------------
module switch_debounce_pulse #(
  parameter int par_T_debounce_bits = 20,
  parameter int par_T_debounce_val  = 1000000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_sw,
  output logic o_sw_level,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b10,
    ST_WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [par_T_debounce_bits-1:0] TIMER_MAX =
    par_T_debounce_bits'(par_T_debounce_val - 1);

  logic                           s_sync1;
  logic                           s_sync2;
  state_t                         s_state;
  state_t                         s_state_nxt;
  logic [par_T_debounce_bits-1:0] s_timer;
  logic                           s_timer_done;

  assign s_timer_done = (s_timer >= TIMER_MAX);

  // Two-flop synchronizer. Only s_sync2 is used by the FSM.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s_sync1 <= 1'b0;
      s_sync2 <= 1'b0;
    end else begin
      s_sync1 <= i_sw;
      s_sync2 <= s_sync1;
    end
  end

  // State register, debounce timer and registered strobes.
  // The timer restarts on every state change, so each wait state always
  // counts a fresh stable interval. The timer saturates and never wraps,
  // so a long stable level cannot trigger a late spurious transition.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s_state         <= ST_LOW;
      s_timer         <= '0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
    end else begin
      s_state <= s_state_nxt;
      if (s_state != s_state_nxt) begin
        s_timer <= '0;
      end else if (!s_timer_done) begin
        s_timer <= s_timer + 1'b1;
      end
      // Strobes fire only on a qualified acceptance. A bounce that returns
      // to the old level goes back through the other edge and stays silent.
      o_press_pulse   <= (s_state == ST_WAIT_HIGH) && (s_state_nxt == ST_HIGH);
      o_release_pulse <= (s_state == ST_WAIT_LOW)  && (s_state_nxt == ST_LOW);
    end
  end

  // Next-state logic.
  always_comb begin
    s_state_nxt = ST_LOW;
    case (s_state)
      ST_LOW: begin
        s_state_nxt = s_sync2 ? ST_WAIT_HIGH : ST_LOW;
      end
      ST_WAIT_HIGH: begin
        if (!s_sync2) begin
          s_state_nxt = ST_LOW;
        end else if (s_timer_done) begin
          s_state_nxt = ST_HIGH;
        end else begin
          s_state_nxt = ST_WAIT_HIGH;
        end
      end
      ST_HIGH: begin
        s_state_nxt = s_sync2 ? ST_HIGH : ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (s_sync2) begin
          s_state_nxt = ST_HIGH;
        end else if (s_timer_done) begin
          s_state_nxt = ST_LOW;
        end else begin
          s_state_nxt = ST_WAIT_LOW;
        end
      end
      default: begin
        s_state_nxt = ST_LOW;
      end
    endcase
  end

  // Moore level output. It stays high while a release is still being qualified.
  assign o_sw_level = (s_state == ST_HIGH) || (s_state == ST_WAIT_LOW);

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce_pulse
//
// Self-checking bench for switch_debounce_pulse (bits=4, val=8).
//
// Reference model:
//   The raw input passes through a two-cycle delay.
//   The debounced level flips once the last val+1 delayed samples seen at
//   clock edges have all differed from the current level.
//
// Test sequence:
//   Directed scenarios with literal expectations come first.
//   Randomized dwell and reset segments follow.
// ---------------------------------------------------------------------------
module tb_switch_debounce_pulse;

  localparam int BITS = 4;
  localparam int VAL  = 8;

  logic i_clk;
  logic i_rstn;
  logic i_sw;
  logic o_sw_level;
  logic o_press_pulse;
  logic o_release_pulse;

  int checks = 0;
  int errors = 0;

  switch_debounce_pulse #(
    .par_T_debounce_bits(BITS),
    .par_T_debounce_val (VAL)
  ) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_sw           (i_sw),
    .o_sw_level     (o_sw_level),
    .o_press_pulse  (o_press_pulse),
    .o_release_pulse(o_release_pulse)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model state.
  logic mS1;
  logic mS2;
  logic mLevel;
  logic mPress;
  logic mRelease;
  logic modelValid = 1'b0;
  logic hist [VAL+1];

  int pressSeen   = 0;
  int releaseSeen = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model, evaluated at each rising edge.
  always @(posedge i_clk) begin
    if (!i_rstn) begin
      mS1        = 1'b0;
      mS2        = 1'b0;
      mLevel     = 1'b0;
      mPress     = 1'b0;
      mRelease   = 1'b0;
      modelValid = 1'b1;
      for (int i = 0; i <= VAL; i++) hist[i] = 1'b0;
    end else if (modelValid) begin
      automatic bit allDiff = 1'b1;
      for (int i = VAL; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = mS2;
      for (int i = 0; i <= VAL; i++) if (hist[i] == mLevel) allDiff = 1'b0;
      mPress   = 1'b0;
      mRelease = 1'b0;
      if (allDiff) begin
        mLevel   = ~mLevel;
        mPress   = mLevel;
        mRelease = ~mLevel;
      end
      mS2 = mS1;
      mS1 = i_sw;
    end
  end

  // Compare process, sampling away from the active edge.
  always @(negedge i_clk) begin
    if (modelValid) begin
      checkOutput("model_level",   o_sw_level,      mLevel);
      checkOutput("model_press",   o_press_pulse,   mPress);
      checkOutput("model_release", o_release_pulse, mRelease);
      if (o_press_pulse)   pressSeen++;
      if (o_release_pulse) releaseSeen++;
    end
  end

  // Drive the inputs at a falling edge, then advance n rising edges.
  // Returns at the falling edge after the n-th rising edge.
  task automatic applyStimulus(input logic sw, input logic rstn, input int n);
    i_sw   = sw;
    i_rstn = rstn;
    repeat (n) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
  endtask

  initial begin
    int p0;
    int r0;
    i_sw   = 1'b0;
    i_rstn = 1'b0;
    @(negedge i_clk);

    // Reset state
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("reset_level",   o_sw_level,      0);
    checkOutput("reset_press",   o_press_pulse,   0);
    checkOutput("reset_release", o_release_pulse, 0);
    applyStimulus(1'b0, 1'b1, 5);

    // Clean press: first high sample at edge k, acceptance at edge k+10
    p0 = pressSeen;
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("press_k9_level", o_sw_level, 0);
    checkOutput("press_k9_pulse", o_press_pulse, 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("press_k10_level", o_sw_level, 1);
    checkOutput("press_k10_pulse", o_press_pulse, 1);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("press_k11_pulse", o_press_pulse, 0);

    // Long hold: the timer saturates and no further pulses appear
    applyStimulus(1'b1, 1'b1, 100);
    checkOutput("timer_saturated", int'(dut.s_timer), VAL - 1);
    checkOutput("single_press", pressSeen - p0, 1);

    // Glitch rejection
    r0 = releaseSeen;
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("glitch_level", o_sw_level, 1);
    checkOutput("glitch_no_release", releaseSeen - r0, 0);

    // Clean release
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("release_k9_level", o_sw_level, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("release_k10_level", o_sw_level, 0);
    checkOutput("release_k10_pulse", o_release_pulse, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("release_k11_pulse", o_release_pulse, 0);
    applyStimulus(1'b0, 1'b1, 20);

    // Bounce on press: 1,0,1,0 with a 3-cycle dwell, then hold high
    p0 = pressSeen;
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("bounce_no_pulse", pressSeen - p0, 0);
    checkOutput("bounce_k9_level", o_sw_level, 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("bounce_k10_pulse", o_press_pulse, 1);
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("bounce_one_press", pressSeen - p0, 1);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("bounce_released", o_sw_level, 0);

    // Reset mid-qualify: reset lands 5 cycles into the high qualification
    applyStimulus(1'b1, 1'b1, 7);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midrst_level",   o_sw_level,      0);
    checkOutput("midrst_press",   o_press_pulse,   0);
    checkOutput("midrst_release", o_release_pulse, 0);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("midrst_r10_press", o_press_pulse, 0);
    checkOutput("midrst_r10_level", o_sw_level, 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midrst_r11_press", o_press_pulse, 1);
    checkOutput("midrst_r11_level", o_sw_level, 1);
    applyStimulus(1'b1, 1'b1, 5);

    // Randomized dwell lengths with occasional resets
    for (int s = 0; s < 400; s++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 29) != 0),
                    int'($urandom_range(1, 14)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
